// File: rtl/program_loader.sv
// program_loader
//   Byte-stream boot loader. Parses framed records from a valid/ready byte
//   stream, assembles big-endian 32-bit words and writes them into RAM via a
//   single write port. The processor is held in reset until an END record.
//
//   Record format: A5 <type> <payload>
//     01 ORG  : addr_hi addr_lo   (low ADDR_W bits become the current address)
//     02 DATA : b3 b2 b1 b0       (word written at current address, address++)
//     03 END  : loader stops, releases processor
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_data byte source
//   in_ready         loader can accept a byte this cycle (registered)
//   mem_we           one-cycle RAM write strobe
//   mem_addr/wdata   RAM write address/data, held between writes
//   proc_rst         processor reset, high until END
//   done, err        sticky END-seen / bad-record-type flags
//   word_count       words written since reset, wraps mod 2^16
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              proc_rst,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        idx;
  logic [23:0]       shift;     // earlier payload bytes, MSB first
  logic [ADDR_W-1:0] cur_addr;
  logic              acc;

  assign acc = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      shift      <= 24'd0;
      cur_addr   <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      proc_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= 16'd0;
    end else begin
      mem_we   <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        S_IDLE: begin
          // anything but a sync byte is dropped here
          if (acc && in_data == 8'hA5) state <= S_TYPE;
        end
        S_TYPE: begin
          if (acc) begin
            case (in_data)
              8'h01: state <= S_ADDR_HI;
              8'h02: begin state <= S_DATA; idx <= 2'd0; end
              8'h03: begin
                state    <= S_DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
                proc_rst <= 1'b0;
              end
              default: begin state <= S_IDLE; err <= 1'b1; end
            endcase
          end
        end
        S_ADDR_HI: begin
          if (acc) begin
            shift <= {shift[15:0], in_data};
            state <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (acc) begin
            cur_addr <= ADDR_W'({shift[7:0], in_data});
            state    <= S_IDLE;
          end
        end
        S_DATA: begin
          if (acc) begin
            if (idx == 2'd3) begin
              // issue the write directly from the 4th byte so the strobe
              // lands in the very next cycle
              mem_we    <= 1'b1;
              mem_addr  <= cur_addr;
              mem_wdata <= DATA_W'({shift, in_data});
              in_ready  <= 1'b0;
              state     <= S_WRITE;
            end else begin
              shift <= {shift[15:0], in_data};
              idx   <= idx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          cur_addr   <= cur_addr + 1'b1;
          word_count <= word_count + 16'd1;
          state      <= S_IDLE;
        end
        S_DONE: begin
          in_ready <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, proc_rst, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] word_count;

  int ntests = 0;
  int nfail  = 0;
  int rdy_bad = 0;
  bit gaps = 1'b0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  program_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .proc_rst(proc_rst), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // write log, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      if (in_ready) rdy_bad++;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    wa.delete(); wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      ntests++; nfail++;
      $display("FAIL send_byte timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] w);
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic send_org(input logic [15:0] a);
    send_byte(8'hA5); send_byte(8'h01); send_byte(a[15:8]); send_byte(a[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    ntests++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    ntests++; if (proc_rst !== 1'b1) begin nfail++; $display("FAIL reset_proc_rst: got %b want 1", proc_rst); end
    ntests++; if (wa.size() != 0 || mem_we !== 1'b0) begin nfail++; $display("FAIL reset_we: writes %0d we %b want 0", wa.size(), mem_we); end
    ntests++; if ({done, err, word_count, mem_addr, mem_wdata} !== 58'd0) begin
      nfail++; $display("FAIL reset_regs: done %b err %b wc %0d addr %h wdata %h want all 0", done, err, word_count, mem_addr, mem_wdata);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    send_data(32'h09800087);
    ntests++; if (mem_we !== 1'b1 || in_ready !== 1'b0) begin
      nfail++; $display("FAIL single_write_cycle: we %b ready %b want 1 0", mem_we, in_ready);
    end
    idle(3);
    ntests++; if (wa.size() != 1) begin nfail++; $display("FAIL single_count: got %0d writes want 1", wa.size()); end
    else if (wa[0] !== 8'h00 || wd[0] !== 32'h09800087) begin
      nfail++; $display("FAIL single_word: got %h@%h want 09800087@00", wd[0], wa[0]);
    end
    ntests++; if (word_count !== 16'd1) begin nfail++; $display("FAIL single_wc: got %0d want 1", word_count); end
    ntests++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h09800087) begin
      nfail++; $display("FAIL single_hold: got %h@%h want 09800087@00", mem_wdata, mem_addr);
    end
  endtask

  task automatic test_org_burst(input bit g);
    gaps = g;
    do_reset();
    send_org(16'h0091);
    send_data(32'h1CD60000);
    send_data(32'hA50000A5);   // sync value inside payload is data
    gaps = 1'b0;
    idle(3);
    ntests++; if (wa.size() != 2) begin nfail++; $display("FAIL org_count gaps=%0d: got %0d want 2", g, wa.size()); end
    else if (wa[0] !== 8'h91 || wd[0] !== 32'h1CD60000 || wa[1] !== 8'h92 || wd[1] !== 32'hA50000A5) begin
      nfail++; $display("FAIL org_words gaps=%0d: got %h@%h %h@%h want 1cd60000@91 a50000a5@92", g, wd[0], wa[0], wd[1], wa[1]);
    end
    ntests++; if (word_count !== 16'd2) begin nfail++; $display("FAIL org_wc gaps=%0d: got %0d want 2", g, word_count); end
  endtask

  task automatic test_wrap_junk();
    do_reset();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    idle(3);
    ntests++; if (wa.size() != 0 || word_count !== 16'd0) begin
      nfail++; $display("FAIL junk: writes %0d wc %0d want 0 0", wa.size(), word_count);
    end
    send_org(16'h12FF);        // upper address bits dropped
    send_data(32'hDEADBEEF);
    send_data(32'h01020304);
    idle(3);
    ntests++; if (wa.size() != 2) begin nfail++; $display("FAIL wrap_count: got %0d want 2", wa.size()); end
    else if (wa[0] !== 8'hFF || wd[0] !== 32'hDEADBEEF || wa[1] !== 8'h00 || wd[1] !== 32'h01020304) begin
      nfail++; $display("FAIL wrap_words: got %h@%h %h@%h want deadbeef@ff 01020304@00", wd[0], wa[0], wd[1], wa[1]);
    end
  endtask

  task automatic test_error();
    do_reset();
    send_byte(8'hA5); send_byte(8'h07);
    ntests++; if (err !== 1'b1) begin nfail++; $display("FAIL err_set: got %b want 1", err); end
    send_data(32'hCAFEBABE);
    idle(3);
    ntests++; if (wa.size() != 1) begin nfail++; $display("FAIL err_count: got %0d want 1", wa.size()); end
    else if (wa[0] !== 8'h00 || wd[0] !== 32'hCAFEBABE) begin
      nfail++; $display("FAIL err_word: got %h@%h want cafebabe@00", wd[0], wa[0]);
    end
    ntests++; if (err !== 1'b1 || done !== 1'b0) begin nfail++; $display("FAIL err_sticky: err %b done %b want 1 0", err, done); end
  endtask

  task automatic test_end_midreset();
    do_reset();
    send_org(16'h0040);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ntests++; if (done !== 1'b0 || proc_rst !== 1'b1) begin nfail++; $display("FAIL pre_end: done %b proc_rst %b want 0 1", done, proc_rst); end
    // a DATA completing here would reveal leftover state from before reset
    send_byte(8'hA5); send_byte(8'h03);
    ntests++; if (done !== 1'b1 || proc_rst !== 1'b0 || in_ready !== 1'b0) begin
      nfail++; $display("FAIL end: done %b proc_rst %b ready %b want 1 0 0", done, proc_rst, in_ready);
    end
    in_valid = 1'b1; in_data = 8'hA5;
    idle(5);
    in_valid = 1'b0;
    ntests++; if (wa.size() != 0 || word_count !== 16'd0 || in_ready !== 1'b0 || done !== 1'b1) begin
      nfail++; $display("FAIL after_end: writes %0d wc %0d ready %b done %b want 0 0 0 1", wa.size(), word_count, in_ready, done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_org_burst(1'b0);
    test_org_burst(1'b1);
    test_wrap_junk();
    test_error();
    test_end_midreset();
    ntests++; if (rdy_bad != 0) begin nfail++; $display("FAIL ready_during_write: got %0d cycles want 0", rdy_bad); end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream boot loader that sits upstream of the processor and its RAM. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them into RAM through a single write port, holding the processor in reset until an END record arrives. It replaces hierarchical memory pokes as the way program images and data (ORG 0 code, ORG $91 code, data words) get into RAM.

## Interface
- ADDR_W, 8: RAM word-address width.
- DATA_W, 32: RAM word width; fixed at 32 (4 bytes per word).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source presents a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle RAM write strobe.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- proc_rst  out  1  holds processor in reset while high.
- done  out  1  sticky; END record received.
- err  out  1  sticky; unknown record type seen.
- word_count  out  16  words written since reset, wraps mod 2^16.

## Operation
- Byte accepted iff in_valid && in_ready on a rising edge. No other byte is consumed. Gaps in in_valid stall the FSM in its current state.
- Record format: sync 0xA5, then a type byte.
  - 0x01 ORG: 2 address bytes, MSB first. Low ADDR_W bits load the current address.
  - 0x02 DATA: 4 data bytes, MSB first. The word is written at the current address, then the address increments.
  - 0x03 END: loader finishes.
- States: IDLE, TYPE, ADDR_HI, ADDR_LO, DATA (2-bit byte index 0..3), WRITE, DONE.
- IDLE: accepted 0xA5 -> TYPE. Any other byte is discarded silently and the FSM stays in IDLE.
- TYPE:
  - 0x01 -> ADDR_HI.
  - 0x02 -> DATA with index 0.
  - 0x03 -> DONE.
  - Any other value -> set err, go to IDLE.
- ADDR_HI -> ADDR_LO -> IDLE. The current address updates when the ADDR_LO byte is accepted.
- DATA: the shift register collects bytes; the 4th byte -> WRITE.
- WRITE: lasts one cycle.
  - mem_we=1, mem_addr=current address, mem_wdata=assembled word.
  - Next cycle: address+1 (wraps 2^ADDR_W-1 -> 0), word_count+1, FSM -> IDLE.
- DONE: terminal until rst. in_ready=0, proc_rst=0, done=1.
- A 0xA5 byte inside ORG or DATA payloads is treated as data, not as a sync.
- Reset mid-record: the partial word is discarded, address returns to 0, FSM returns to IDLE. No write is issued.

## Timing
- Reset values (cycle after rst is sampled high, and while held): in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, proc_rst=1, done=0, err=0, word_count=0, state IDLE.
- in_ready=1 in IDLE, TYPE, ADDR_HI, ADDR_LO and DATA from the first cycle after rst deasserts. in_ready=0 in WRITE and DONE.
- DATA latency: 4th data byte accepted at edge N -> mem_we high for exactly the cycle after N. The next byte can be accepted at edge N+2.
- mem_addr/mem_wdata are stable while mem_we=1. Between writes they hold their last values.
- ORG effect: the address is usable by a DATA record whose sync arrives on the very next cycle.
- END accepted at edge N -> done=1 and proc_rst=0 in the cycle after N.
- err asserts the cycle after the bad type byte and stays high until rst. Loading continues normally after an error.
- Throughput: one DATA record = 6 byte cycles + 1 write cycle.

## Test plan
- Reset: hold rst 3 cycles while in_valid=1 -> in_ready=0, proc_rst=1, mem_we never asserted, all counters 0.
- Single word: stream A5 02 09 80 00 87 -> exactly one mem_we pulse, addr 0x00, wdata 0x09800087, word_count=1, in_ready low during the WRITE cycle.
- ORG + burst: A5 01 00 91, then A5 02 1C D6 00 00, then a second DATA record -> writes at 0x91 and 0x92. Random in_valid gaps produce identical results.
- Wrap and junk: ORG 0xFF, two DATA records -> writes at 0xFF then 0x00. Leading junk bytes 00 FF 12 before the sync are ignored with no writes.
- Error: A5 07, then a valid DATA record -> err=1 sticky, the DATA record is still written correctly.
- END and mid-record reset: send A5 02 11 22, pulse rst, then A5 03 -> no write occurs, and done=1, proc_rst=0 one cycle after the END byte. Further bytes see in_ready=0.
